// File: rtl/mul_div_issue_queue_if.sv
// Dispatch, writeback-broadcast and issue bus between rename/dispatch, the mul/div issue queue and fu_mul/fu_div.
// Latency: none (wires only).
// Backpressure: disp_ready from the queue; mul_ready/div_ready from the functional units.
`ifndef ROB_DEPTH
`define ROB_DEPTH 16
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef DATA_WIDTH_ALU_OP
`define DATA_WIDTH_ALU_OP 6
`endif

interface mul_div_issue_queue_if #(
  parameter int IQ_DEPTH = 4,
  parameter int WB_PORTS = 3,
  parameter int TAG_W    = $clog2(`ROB_DEPTH)
);
  logic                               flush;
  logic                               disp_valid;
  logic                               disp_ready;
  logic [`DATA_WIDTH_ALU_OP-1:0]      disp_op;
  logic                               disp_is_div;
  logic                               disp_rs1_rdy;
  logic                               disp_rs2_rdy;
  logic [TAG_W-1:0]                   disp_rs1_tag;
  logic [TAG_W-1:0]                   disp_rs2_tag;
  logic [`WORD_WIDTH-1:0]             disp_rs1_value;
  logic [`WORD_WIDTH-1:0]             disp_rs2_value;
  logic [TAG_W-1:0]                   disp_Pdst;
  logic [WB_PORTS-1:0]                wb_valid;
  logic [WB_PORTS*TAG_W-1:0]          wb_Paddr;
  logic [WB_PORTS*`WORD_WIDTH-1:0]    wb_value;
  logic                               mul_ready;
  logic                               div_ready;
  logic                               mul_div_issue_en;
  logic [`DATA_WIDTH_ALU_OP-1:0]      mul_div_issue_queue_op;
  logic [`WORD_WIDTH-1:0]             mul_div_issue_queue_rs1_value;
  logic [`WORD_WIDTH-1:0]             mul_div_issue_queue_rs2_value;
  logic [TAG_W-1:0]                   mul_div_issue_queue_Pdst;
  logic [$clog2(IQ_DEPTH+1)-1:0]      iq_count;

  // Queue side
  modport slave (
    input  flush, disp_valid, disp_op, disp_is_div,
    input  disp_rs1_rdy, disp_rs2_rdy, disp_rs1_tag, disp_rs2_tag,
    input  disp_rs1_value, disp_rs2_value, disp_Pdst,
    input  wb_valid, wb_Paddr, wb_value, mul_ready, div_ready,
    output disp_ready, mul_div_issue_en, mul_div_issue_queue_op,
    output mul_div_issue_queue_rs1_value, mul_div_issue_queue_rs2_value,
    output mul_div_issue_queue_Pdst, iq_count
  );

  // Dispatch / writeback / functional-unit side
  modport master (
    output flush, disp_valid, disp_op, disp_is_div,
    output disp_rs1_rdy, disp_rs2_rdy, disp_rs1_tag, disp_rs2_tag,
    output disp_rs1_value, disp_rs2_value, disp_Pdst,
    output wb_valid, wb_Paddr, wb_value, mul_ready, div_ready,
    input  disp_ready, mul_div_issue_en, mul_div_issue_queue_op,
    input  mul_div_issue_queue_rs1_value, mul_div_issue_queue_rs2_value,
    input  mul_div_issue_queue_Pdst, iq_count
  );
endinterface

// File: rtl/mul_div_issue_queue.sv
// Mul/div reservation queue: compacting age-ordered shift queue, wakeup from writeback, oldest-ready issue.
// Latency: dispatch-to-issue 1 cycle min (0 with IQ_EMPTY_BYPASS_EN defined on an empty queue); wakeup-to-issue 1 cycle.
// Backpressure: disp_ready = registered count < IQ_DEPTH; an entry only issues when its target unit is ready.
`ifndef ROB_DEPTH
`define ROB_DEPTH 16
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef DATA_WIDTH_ALU_OP
`define DATA_WIDTH_ALU_OP 6
`endif

module mul_div_issue_queue #(
  parameter int IQ_DEPTH = 4,
  parameter int WB_PORTS = 3,
  parameter int TAG_W    = $clog2(`ROB_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  mul_div_issue_queue_if.slave  bus
);
  localparam int CNT_W  = $clog2(IQ_DEPTH+1);
  localparam int IDX_W  = $clog2(IQ_DEPTH);
  localparam int OP_W   = `DATA_WIDTH_ALU_OP;
  localparam int WORD_W = `WORD_WIDTH;

  typedef struct packed {
    logic              rdy;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] value;
  } src_t;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic             is_div;
    src_t             rs1;
    src_t             rs2;
    logic [TAG_W-1:0] pdst;
  } entry_t;

  entry_t           ent_q [IQ_DEPTH];
  entry_t           ent_d [IQ_DEPTH];
  // One extra always-empty slot so the top entry shifts in zero.
  entry_t           woken [IQ_DEPTH+1];
  entry_t           disp_ent;
  entry_t           iss_ent;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_after;
  logic             sel_vld;
  logic [IDX_W-1:0] sel_idx;
  logic             iss_vld;
  logic             issue_rm;
  logic             disp_fire;
`ifdef IQ_EMPTY_BYPASS_EN
  logic             byp_vld;
`endif

  // Capture a not-ready source from the broadcast ports; lowest port index wins.
  function automatic src_t snoop(input src_t s,
                                 input logic [WB_PORTS-1:0] v,
                                 input logic [WB_PORTS*TAG_W-1:0] a,
                                 input logic [WB_PORTS*WORD_W-1:0] d);
    src_t r;
    r = s;
    if (!s.rdy) begin
      for (int p = WB_PORTS-1; p >= 0; p--) begin
        if (v[p] && (a[p*TAG_W +: TAG_W] == s.tag)) begin
          r.rdy   = 1'b1;
          r.value = d[p*WORD_W +: WORD_W];
        end
      end
    end
    return r;
  endfunction

  function automatic logic eligible(input entry_t e, input logic mul_rdy, input logic div_rdy);
    return e.valid && e.rs1.rdy && e.rs2.rdy && (e.is_div ? div_rdy : mul_rdy);
  endfunction

  // Wakeup: stored entries snoop the current broadcast (visible to issue next cycle).
  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++) begin
      woken[i] = ent_q[i];
      if (ent_q[i].valid) begin
        woken[i].rs1 = snoop(ent_q[i].rs1, bus.wb_valid, bus.wb_Paddr, bus.wb_value);
        woken[i].rs2 = snoop(ent_q[i].rs2, bus.wb_valid, bus.wb_Paddr, bus.wb_value);
      end
    end
    woken[IQ_DEPTH] = '0;
  end

  // Incoming op, including same-cycle broadcast capture.
  always_comb begin
    disp_ent        = '0;
    disp_ent.valid  = 1'b1;
    disp_ent.op     = bus.disp_op;
    disp_ent.is_div = bus.disp_is_div;
    disp_ent.rs1    = snoop('{rdy: bus.disp_rs1_rdy, tag: bus.disp_rs1_tag, value: bus.disp_rs1_value},
                            bus.wb_valid, bus.wb_Paddr, bus.wb_value);
    disp_ent.rs2    = snoop('{rdy: bus.disp_rs2_rdy, tag: bus.disp_rs2_tag, value: bus.disp_rs2_value},
                            bus.wb_valid, bus.wb_Paddr, bus.wb_value);
    disp_ent.pdst   = bus.disp_Pdst;
  end

  // Select the oldest eligible registered entry.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = IQ_DEPTH-1; i >= 0; i--) begin
      if (eligible(ent_q[i], bus.mul_ready, bus.div_ready)) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

`ifdef IQ_EMPTY_BYPASS_EN
  // Empty-queue bypass: a fully ready op goes straight to its unit.
  always_comb begin
    byp_vld = (count_q == '0) && !bus.flush && bus.disp_valid &&
              disp_ent.rs1.rdy && disp_ent.rs2.rdy &&
              (bus.disp_is_div ? bus.div_ready : bus.mul_ready);
  end
`endif

  // Issue bus: selected entry (or bypassed op), zero otherwise; flush suppresses issue.
  always_comb begin
    iss_vld = 1'b0;
    iss_ent = '0;
    if (!bus.flush) begin
      if (sel_vld) begin
        iss_vld = 1'b1;
        iss_ent = ent_q[sel_idx];
      end
`ifdef IQ_EMPTY_BYPASS_EN
      else if (byp_vld) begin
        iss_vld = 1'b1;
        iss_ent = disp_ent;
      end
`endif
    end
  end

  assign bus.mul_div_issue_en              = iss_vld;
  assign bus.mul_div_issue_queue_op        = iss_ent.op;
  assign bus.mul_div_issue_queue_rs1_value = iss_ent.rs1.value;
  assign bus.mul_div_issue_queue_rs2_value = iss_ent.rs2.value;
  assign bus.mul_div_issue_queue_Pdst      = iss_ent.pdst;
  assign bus.disp_ready                    = (count_q < CNT_W'(IQ_DEPTH));
  assign bus.iq_count                      = count_q;

  // Next state: remove issued entry with compaction, then append the dispatch at the first free slot.
  always_comb begin
    issue_rm    = sel_vld && !bus.flush;
`ifdef IQ_EMPTY_BYPASS_EN
    disp_fire   = bus.disp_valid && bus.disp_ready && !bus.flush && !byp_vld;
`else
    disp_fire   = bus.disp_valid && bus.disp_ready && !bus.flush;
`endif
    count_after = count_q - CNT_W'(issue_rm);
    count_d     = count_after + CNT_W'(disp_fire);
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (issue_rm && (i >= int'(sel_idx))) begin
        ent_d[i] = woken[i+1];
      end else begin
        ent_d[i] = woken[i];
      end
      if (disp_fire && (CNT_W'(i) == count_after)) begin
        ent_d[i] = disp_ent;
      end
    end
    if (bus.flush) begin
      count_d = '0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
        ent_d[i] = '0;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end
endmodule

// File: tb/tb_mul_div_issue_queue.sv
// Directed bench for mul_div_issue_queue: scoreboard of expected issues plus per-cycle timing checks.
// Latency: checks sampled on the falling edge; inputs driven 1ns after the rising edge.
// Backpressure: exercises disp_ready, mul_ready/div_ready stalls, flush and reset.
`ifndef ROB_DEPTH
`define ROB_DEPTH 16
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef DATA_WIDTH_ALU_OP
`define DATA_WIDTH_ALU_OP 6
`endif

module tb_mul_div_issue_queue;
  localparam int IQ_DEPTH = 4;
  localparam int WB_PORTS = 3;
  localparam int TAG_W    = 4;
  localparam logic [5:0] OP_MUL = 6'd10;
  localparam logic [5:0] OP_DIV = 6'd14;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [3:0]  pdst;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  exp_t sb [$];

  mul_div_issue_queue_if #(.IQ_DEPTH(IQ_DEPTH), .WB_PORTS(WB_PORTS), .TAG_W(TAG_W)) bus ();

  mul_div_issue_queue #(.IQ_DEPTH(IQ_DEPTH), .WB_PORTS(WB_PORTS), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2, input logic [3:0] pdst);
    exp_t e;
    e.op = op; e.v1 = v1; e.v2 = v2; e.pdst = pdst;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [5:0] op, input logic is_div,
                      input logic r1rdy, input logic [3:0] r1tag, input logic [31:0] r1val,
                      input logic r2rdy, input logic [3:0] r2tag, input logic [31:0] r2val,
                      input logic [3:0] pdst);
    bus.disp_valid     = 1'b1;
    bus.disp_op        = op;
    bus.disp_is_div    = is_div;
    bus.disp_rs1_rdy   = r1rdy;
    bus.disp_rs1_tag   = r1tag;
    bus.disp_rs1_value = r1val;
    bus.disp_rs2_rdy   = r2rdy;
    bus.disp_rs2_tag   = r2tag;
    bus.disp_rs2_value = r2val;
    bus.disp_Pdst      = pdst;
  endtask

  task automatic nodisp();
    bus.disp_valid = 1'b0;
  endtask

  task automatic wb(input int port, input logic [3:0] tag, input logic [31:0] val);
    bus.wb_valid[port]                = 1'b1;
    bus.wb_Paddr[port*TAG_W +: TAG_W] = tag;
    bus.wb_value[port*32 +: 32]       = val;
  endtask

  // Scoreboard monitor: every issue must match the next expected op.
  always @(negedge clk) begin
    if (!rst && bus.mul_div_issue_en) begin
      chk("issue_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_op",   64'(bus.mul_div_issue_queue_op),        64'(e.op));
        chk("sb_rs1",  64'(bus.mul_div_issue_queue_rs1_value), 64'(e.v1));
        chk("sb_rs2",  64'(bus.mul_div_issue_queue_rs2_value), 64'(e.v2));
        chk("sb_pdst", 64'(bus.mul_div_issue_queue_Pdst),      64'(e.pdst));
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.disp_valid = 1'b0; bus.disp_op = '0; bus.disp_is_div = 1'b0;
    bus.disp_rs1_rdy = 1'b0; bus.disp_rs2_rdy = 1'b0;
    bus.disp_rs1_tag = '0; bus.disp_rs2_tag = '0;
    bus.disp_rs1_value = '0; bus.disp_rs2_value = '0; bus.disp_Pdst = '0;
    bus.wb_valid = '0; bus.wb_Paddr = '0; bus.wb_value = '0;
    bus.mul_ready = 1'b1; bus.div_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_count", 64'(bus.iq_count), 64'd0);
    chk("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
    chk("rst_issue_en", 64'(bus.mul_div_issue_en), 64'd0);
    chk("rst_issue_pdst", 64'(bus.mul_div_issue_queue_Pdst), 64'd0);
    chk("rst_issue_rs1", 64'(bus.mul_div_issue_queue_rs1_value), 64'd0);

    // Basic MUL, one-cycle dispatch-to-issue.
    tick(); disp(OP_MUL, 1'b0, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 32'd6, 4'd3); push(OP_MUL, 32'd7, 32'd6, 4'd3);
    @(negedge clk); chk("t1_no_issue_disp_cycle", 64'(bus.mul_div_issue_en), 64'd0);
    tick(); nodisp();
    @(negedge clk); chk("t1_issue_en", 64'(bus.mul_div_issue_en), 64'd1);
    chk("t1_count_1", 64'(bus.iq_count), 64'd1);
    tick();
    @(negedge clk); chk("t1_count_0", 64'(bus.iq_count), 64'd0);
    chk("t1_idle", 64'(bus.mul_div_issue_en), 64'd0);

    // DIV waiting on tag 5, woken by wb port1 at N+2, issues at N+3.
    tick(); disp(OP_DIV, 1'b1, 1'b1, 4'd0, 32'd100, 1'b0, 4'd5, 32'd0, 4'd7); push(OP_DIV, 32'd100, 32'h10, 4'd7);
    @(negedge clk); chk("t2_n0", 64'(bus.mul_div_issue_en), 64'd0);
    tick(); nodisp();
    @(negedge clk); chk("t2_n1", 64'(bus.mul_div_issue_en), 64'd0);
    tick(); wb(1, 4'd5, 32'h10);
    @(negedge clk); chk("t2_n2", 64'(bus.mul_div_issue_en), 64'd0);
    tick(); bus.wb_valid = '0;
    @(negedge clk); chk("t2_n3_issue", 64'(bus.mul_div_issue_en), 64'd1);
    chk("t2_rs2", 64'(bus.mul_div_issue_queue_rs2_value), 64'h10);
    tick();
    @(negedge clk); chk("t2_count_0", 64'(bus.iq_count), 64'd0);

    // Fill, full backpressure, drop a 5th, then drain in order.
    bus.mul_ready = 1'b0;
    for (int p = 1; p <= 4; p++) begin
      tick(); disp(OP_MUL, 1'b0, 1'b1, 4'd0, 32'(p*10), 1'b1, 4'd0, 32'(p), 4'(p));
      push(OP_MUL, 32'(p*10), 32'(p), 4'(p));
    end
    tick(); disp(OP_MUL, 1'b0, 1'b1, 4'd0, 32'd99, 1'b1, 4'd0, 32'd99, 4'd9);
    @(negedge clk); chk("t3_full_count", 64'(bus.iq_count), 64'd4);
    chk("t3_disp_ready_0", 64'(bus.disp_ready), 64'd0);
    chk("t3_no_issue", 64'(bus.mul_div_issue_en), 64'd0);
    tick(); nodisp(); bus.mul_ready = 1'b1;
    @(negedge clk); chk("t3_issue_1", 64'(bus.mul_div_issue_queue_Pdst), 64'd1);
    for (int p = 2; p <= 4; p++) begin
      tick();
      @(negedge clk); chk("t3_issue_en", 64'(bus.mul_div_issue_en), 64'd1);
      chk("t3_issue_pdst", 64'(bus.mul_div_issue_queue_Pdst), 64'(p));
      chk("t3_count", 64'(bus.iq_count), 64'(5 - p));
    end
    tick();
    @(negedge clk); chk("t3_count_0", 64'(bus.iq_count), 64'd0);
    chk("t3_idle", 64'(bus.mul_div_issue_en), 64'd0);

    // Blocked DIV at entry0, ready MUL behind it issues first.
    bus.mul_ready = 1'b0; bus.div_ready = 1'b0;
    tick(); disp(OP_DIV, 1'b1, 1'b1, 4'd0, 32'd50, 1'b1, 4'd0, 32'd5, 4'd10);
    tick(); disp(OP_MUL, 1'b0, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 32'd4, 4'd11);
    push(OP_MUL, 32'd3, 32'd4, 4'd11); push(OP_DIV, 32'd50, 32'd5, 4'd10);
    tick(); nodisp(); bus.mul_ready = 1'b1;
    @(negedge clk); chk("t4_mul_first", 64'(bus.mul_div_issue_queue_Pdst), 64'd11);
    tick(); bus.div_ready = 1'b1;
    @(negedge clk); chk("t4_div_second", 64'(bus.mul_div_issue_queue_Pdst), 64'd10);
    chk("t4_div_en", 64'(bus.mul_div_issue_en), 64'd1);
    tick();
    @(negedge clk); chk("t4_count_0", 64'(bus.iq_count), 64'd0);

    // Dispatch-cycle snoop; two matching ports, lowest index wins.
    bus.mul_ready = 1'b0;
    tick(); disp(OP_MUL, 1'b0, 1'b0, 4'd6, 32'd0, 1'b1, 4'd0, 32'd3, 4'd12);
    wb(1, 4'd6, 32'h66); wb(2, 4'd6, 32'h77); push(OP_MUL, 32'h66, 32'd3, 4'd12);
    tick(); nodisp(); bus.wb_valid = '0; bus.mul_ready = 1'b1;
    @(negedge clk); chk("t5_snoop_issue", 64'(bus.mul_div_issue_en), 64'd1);
    chk("t5_snoop_value", 64'(bus.mul_div_issue_queue_rs1_value), 64'h66);
    tick();
    @(negedge clk); chk("t5_count_0", 64'(bus.iq_count), 64'd0);

    // Simultaneous issue and dispatch keeps the count.
    bus.mul_ready = 1'b0;
    tick(); disp(OP_MUL, 1'b0, 1'b1, 4'd0, 32'd13, 1'b1, 4'd0, 32'd1, 4'd13); push(OP_MUL, 32'd13, 32'd1, 4'd13);
    tick(); disp(OP_MUL, 1'b0, 1'b1, 4'd0, 32'd14, 1'b1, 4'd0, 32'd1, 4'd14); push(OP_MUL, 32'd14, 32'd1, 4'd14);
    tick(); disp(OP_MUL, 1'b0, 1'b1, 4'd0, 32'd15, 1'b1, 4'd0, 32'd1, 4'd15); push(OP_MUL, 32'd15, 32'd1, 4'd15);
    bus.mul_ready = 1'b1;
    @(negedge clk); chk("t6_issue_13", 64'(bus.mul_div_issue_queue_Pdst), 64'd13);
    chk("t6_count_before", 64'(bus.iq_count), 64'd2);
    tick(); nodisp();
    @(negedge clk); chk("t6_count_kept", 64'(bus.iq_count), 64'd2);
    chk("t6_issue_14", 64'(bus.mul_div_issue_queue_Pdst), 64'd14);
    tick();
    @(negedge clk); chk("t6_issue_15", 64'(bus.mul_div_issue_queue_Pdst), 64'd15);
    tick();
    @(negedge clk); chk("t6_count_0", 64'(bus.iq_count), 64'd0);

    // Flush with 3 entries and a concurrent dispatch.
    bus.mul_ready = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      tick(); disp(OP_MUL, 1'b0, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1, 4'(p));
    end
    tick(); disp(OP_MUL, 1'b0, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1, 4'd4);
    bus.flush = 1'b1; bus.mul_ready = 1'b1;
    @(negedge clk); chk("t7_flush_no_issue", 64'(bus.mul_div_issue_en), 64'd0);
    chk("t7_flush_count_pre", 64'(bus.iq_count), 64'd3);
    tick(); nodisp(); bus.flush = 1'b0;
    @(negedge clk); chk("t7_flush_count", 64'(bus.iq_count), 64'd0);
    chk("t7_flush_ready", 64'(bus.disp_ready), 64'd1);
    chk("t7_flush_idle", 64'(bus.mul_div_issue_en), 64'd0);

    // Synchronous reset mid-queue.
    bus.mul_ready = 1'b0;
    for (int p = 1; p <= 2; p++) begin
      tick(); disp(OP_MUL, 1'b0, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 32'd2, 4'(p));
    end
    tick(); nodisp(); rst = 1'b1;
    @(negedge clk); chk("t8_pre_rst_count", 64'(bus.iq_count), 64'd2);
    tick(); rst = 1'b0; bus.mul_ready = 1'b1;
    @(negedge clk); chk("t8_rst_count", 64'(bus.iq_count), 64'd0);
    chk("t8_rst_ready", 64'(bus.disp_ready), 64'd1);
    chk("t8_rst_idle", 64'(bus.mul_div_issue_en), 64'd0);

    tick();
    @(negedge clk); chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
